i2s_wave_sequencer: RTL and testbench

Sample sequencer between the waveform lookup table and the I2S transmit path. Paces table reads at the audio sample rate, steps and wraps the table position, and offers each sample as a 32-bit stereo word to the downstream I2S writer over a valid/ready handshake. Counts dropped sample ticks when the consumer stalls.

---
 rtl/i2s_wave_pkg.sv | 18 +
 rtl/i2s_sample_rate_divider.sv | 34 +++
 rtl/i2s_wave_sequencer.sv | 98 +++++++++
 tb/tb_i2s_wave_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_wave_pkg.sv
// Shared types and constants for the I2S waveform sequencer.
// The optional I2S_WAVE_VOLUME_EN macro is consumed by i2s_wave_sequencer, not here.
package i2s_wave_pkg;

  localparam int SAMPLE_W = 16;
  localparam int STEREO_W = 32;

  typedef enum logic {
    WAIT  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Clocks per sample tick; integer truncation of the rate ratio.
  function automatic int calc_divisor(input int clock_rate, input int sample_rate);
    return clock_rate / sample_rate;
  endfunction

endpackage

// File: rtl/i2s_sample_rate_divider.sv
// Sample-rate divider: counts 0..DIVISOR-1 while enabled and pulses tick on the last count.
// Disabling clears the count, so the first tick after enable is DIVISOR cycles later.
module i2s_sample_rate_divider #(
  parameter int DIVISOR = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2s_wave_sequencer.sv
// Paces waveform table reads at the sample rate and offers stereo words over valid/ready.
// Define I2S_WAVE_VOLUME_EN to add the volume port (arithmetic right-shift attenuation).
module i2s_wave_sequencer
  import i2s_wave_pkg::*;
#(
  parameter int CLOCK_RATE  = 50000000,
  parameter int SAMPLE_RATE = 44100,
  parameter int DIVISOR     = calc_divisor(CLOCK_RATE, SAMPLE_RATE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [7:0]          wavelength,
  output logic [7:0]          pos,
  input  logic [SAMPLE_W-1:0] value,
  output logic [STEREO_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [7:0]          overrun_count
`ifdef I2S_WAVE_VOLUME_EN
  ,
  input  logic [3:0]          volume
`endif
);

  state_t                state_q, state_d;
  logic [7:0]            pos_q, pos_d;
  logic [7:0]            ovr_q, ovr_d;
  logic [STEREO_W-1:0]   data_q, data_d;
  logic                  tick;
  logic [SAMPLE_W-1:0]   s;
  logic [8:0]            pos_inc;
  logic [8:0]            eff_len;

  i2s_sample_rate_divider #(
    .DIVISOR (DIVISOR)
  ) u_divider (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

`ifdef I2S_WAVE_VOLUME_EN
  assign s = SAMPLE_W'($signed(value) >>> volume);
`else
  assign s = value;
`endif

  // A zero-length table behaves as length one so pos parks at 0.
  assign eff_len = (wavelength == 8'd0) ? 9'd1 : {1'b0, wavelength};
  assign pos_inc = {1'b0, pos_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    case (state_q)
      WAIT: begin
        if (tick) begin
          data_d  = {s, s};
          pos_d   = (pos_inc >= eff_len) ? 8'd0 : pos_inc[7:0];
          state_d = OFFER;
        end
      end
      OFFER: begin
        // Any tick while a word is still outstanding is dropped, even on the handshake cycle.
        if (tick && (ovr_q != 8'hFF)) begin
          ovr_d = ovr_q + 8'd1;
        end
        if (sample_ready) begin
          state_d = WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
      pos_q   <= '0;
      data_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pos           = pos_q;
  assign sample_data   = data_q;
  assign sample_valid  = (state_q == OFFER);
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_i2s_wave_sequencer.sv
// Scoreboard bench for i2s_wave_sequencer: a rate/handshake model predicts words, pos and drops.
// Builds with or without I2S_WAVE_VOLUME_EN.
`timescale 1ns/1ps
module tb_i2s_wave_sequencer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  wavelength;
  logic [7:0]  pos;
  logic [15:0] value;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  overrun_count;
`ifdef I2S_WAVE_VOLUME_EN
  logic [3:0]  volume;
`endif

  logic [15:0] tbl [256];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state
  int          m_run;
  logic [7:0]  m_pos;
  logic        m_pend;
  int          m_ovr;

  always #5 clk = ~clk;

  assign value = tbl[pos];

  i2s_wave_sequencer #(
    .CLOCK_RATE  (4),
    .SAMPLE_RATE (1),
    .DIVISOR     (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .wavelength    (wavelength),
    .pos           (pos),
    .value         (value),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun_count (overrun_count)
`ifdef I2S_WAVE_VOLUME_EN
    ,
    .volume        (volume)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] smp(input logic [15:0] v);
`ifdef I2S_WAVE_VOLUME_EN
    return 16'($signed(v) >>> volume);
`else
    return v;
`endif
  endfunction

  // Behavioural model: ticks every D-th consecutive enabled cycle; one word outstanding at most.
  initial begin
    m_run = 0; m_pos = 8'd0; m_pend = 1'b0; m_ovr = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_run = 0; m_pos = 8'd0; m_pend = 1'b0; m_ovr = 0;
        exp_q.delete();
      end else begin
        logic tk;
        logic hs;
        int   len;
        tk = enable && ((m_run % D) == D - 1);
        hs = m_pend && sample_ready;
        m_run = enable ? m_run + 1 : 0;
        if (tk) begin
          if (m_pend) begin
            m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
          end else begin
            exp_q.push_back({smp(tbl[m_pos]), smp(tbl[m_pos])});
            len = (wavelength == 8'd0) ? 1 : int'(wavelength);
            m_pos = ((int'(m_pos) + 1) >= len) ? 8'd0 : m_pos + 8'd1;
            m_pend = 1'b1;
          end
        end
        if (hs) m_pend = 1'b0;
      end
    end
  end

  // Monitor: compares DUT outputs on the falling edge; pops the scoreboard on each transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        check("valid", 32'(sample_valid), 32'(m_pend));
        check("pos", 32'(pos), 32'(m_pos));
        check("overrun", 32'(overrun_count), 32'(m_ovr));
        if (sample_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL data: offered %h with no expected sample at %0t", sample_data, $time);
          end else begin
            check("data", sample_data, exp_q[0]);
            if (sample_ready) begin
              $display("xfer data=%h pos_after=%0d ovr=%0d", sample_data, pos, overrun_count);
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!sample_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!sample_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: no sample_valid within %0d cycles at %0t", budget, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; sample_ready = 1'b0; wavelength = 8'd44;
`ifdef I2S_WAVE_VOLUME_EN
    volume = 4'd0;
`endif
    for (int i = 0; i < 256; i++) tbl[i] = 16'($urandom);
    tbl[0] = 16'h0000;
    tbl[1] = 16'h1237;
    #12;
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_data", sample_data, 32'd0);
    check("rst_overrun", 32'(overrun_count), 32'd0);

    // Free-running with ready held high: first two words are fixed by the table.
    cycles(1);
    rst = 1'b1; enable = 1'b1; sample_ready = 1'b1;
    @(negedge clk);
    wait_valid(2 * D + 2);
    check("first_word", sample_data, 32'h0000_0000);
    @(negedge clk);
    wait_valid(2 * D + 2);
    check("second_word", sample_data, 32'h1237_1237);
    cycles(44 * D + 16);

    // Backpressure
    sample_ready = 1'b0;
    cycles(10);
    sample_ready = 1'b1;
    cycles(12);

    // Randomized traffic with table length and enable changes
    for (int i = 0; i < 800; i++) begin
      sample_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) wavelength = 8'($urandom_range(0, 50));
      if ($urandom_range(0, 59) == 0) enable = ~enable;
`ifdef I2S_WAVE_VOLUME_EN
      if ($urandom_range(0, 29) == 0) volume = 4'($urandom);
`endif
      cycles(1);
    end
    enable = 1'b1; sample_ready = 1'b1;

    // Short table, then zero-length table
    wavelength = 8'd3;
    cycles(60);
    wavelength = 8'd0;
    cycles(40);
    wavelength = 8'd44;

    // Disable while a word is offered
    sample_ready = 1'b0;
    @(negedge clk);
    wait_valid(2 * D + 2);
    cycles(1);
    enable = 1'b0;
    cycles(5);
    sample_ready = 1'b1;
    cycles(20);
    check("disabled_idle", 32'(sample_valid), 32'd0);
    enable = 1'b1;
    cycles(20);

    // Asynchronous reset while a word is offered
    sample_ready = 1'b0;
    @(negedge clk);
    wait_valid(2 * D + 2);
    #2 rst = 1'b0;
    #1;
    check("async_valid", 32'(sample_valid), 32'd0);
    check("async_pos", 32'(pos), 32'd0);
    check("async_data", sample_data, 32'd0);
    check("async_overrun", 32'(overrun_count), 32'd0);
    cycles(1);
    rst = 1'b1; sample_ready = 1'b1;
    cycles(40);

    // Overrun saturation
    sample_ready = 1'b0;
    cycles(1100);
    @(negedge clk);
    check("ovr_saturate", 32'(overrun_count), 32'd255);
    cycles(1);
    sample_ready = 1'b1;
    cycles(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
